// File: rtl/ply_unit.sv
// Square-wave note player behind a single PLY command: plays a tone of a given
// half-period, volume and tick-length, then pulses done for one cycle.
module ply_unit #(
  parameter int DATA_W   = 16,
  parameter int TICK_DIV = 1000,
  parameter int VOL_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ply_valid,
  output logic              ply_ready,
  input  logic [DATA_W-1:0] ply_period,
  input  logic [DATA_W-1:0] ply_duration,
  input  logic [VOL_W-1:0]  ply_volume,
  input  logic              ply_abort,
  output logic [VOL_W-1:0]  audio_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        o_dbg_state
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DATA_W-1:0]  r_period;
  logic [DATA_W-1:0]  r_dur;
  logic [VOL_W-1:0]   r_vol;
  logic [DATA_W-1:0]  r_phase_cnt;
  logic               r_phase;
  logic [PRE_W-1:0]   r_presc;
  logic               w_handshake;
  logic               w_tick_wrap;

  // Handshake: a command is taken on a rising edge where ply_valid and
  // ply_ready are both 1; ready is only offered in IDLE and never during reset.
  assign ply_ready   = (r_state == S_IDLE) && rst_n;
  assign w_handshake = ply_valid && ply_ready;
  assign w_tick_wrap = (r_presc == PRE_W'(TICK_DIV - 1));

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign audio_out   = ((r_state == S_PLAY) && r_phase && (r_period != '0)) ? r_vol : '0;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_next_state = (ply_duration != '0) ? S_PLAY : S_DONE;
        end
      end
      S_PLAY: begin
        // Abort takes priority over a coincident final tick.
        if (ply_abort) begin
          w_next_state = S_IDLE;
        end else if (w_tick_wrap && (r_dur == DATA_W'(1))) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period    <= '0;
      r_dur       <= '0;
      r_vol       <= '0;
      r_phase_cnt <= '0;
      r_phase     <= 1'b0;
      r_presc     <= '0;
    end else if (w_handshake) begin
      r_period    <= ply_period;
      r_dur       <= ply_duration;
      r_vol       <= ply_volume;
      r_phase_cnt <= '0;
      r_phase     <= 1'b1;
      r_presc     <= '0;
    end else if (r_state == S_PLAY) begin
      // A rest (period 0) holds the phase counter; audio is muted anyway.
      if (r_period != '0) begin
        if (r_phase_cnt == r_period - 1'b1) begin
          r_phase_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_phase_cnt <= r_phase_cnt + 1'b1;
        end
      end
      if (w_tick_wrap) begin
        r_presc <= '0;
        r_dur   <= r_dur - 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end else begin
      r_phase_cnt <= '0;
      r_phase     <= 1'b0;
      r_presc     <= '0;
      r_dur       <= '0;
    end
  end

endmodule

// File: tb/tb_ply_unit.sv
// Bench for ply_unit: directed scenarios plus random notes, each checked
// against a cycle list derived from the note rules (period, ticks, volume).
module tb_ply_unit;
  localparam int DATA_W   = 16;
  localparam int TICK_DIV = 4;
  localparam int VOL_W    = 8;
  localparam int OW       = VOL_W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ply_valid = 1'b0;
  logic              ply_abort = 1'b0;
  logic [DATA_W-1:0] ply_period = '0;
  logic [DATA_W-1:0] ply_duration = '0;
  logic [VOL_W-1:0]  ply_volume = '0;
  logic              ply_ready;
  logic              busy;
  logic              done;
  logic [VOL_W-1:0]  audio_out;
  logic [1:0]        dbg_state;

  logic [OW-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  wire [OW-1:0] obs = {audio_out, busy, done, ply_ready};

  ply_unit #(.DATA_W(DATA_W), .TICK_DIV(TICK_DIV), .VOL_W(VOL_W)) dut (
    .clk(clk), .rst_n(rst_n), .ply_valid(ply_valid), .ply_ready(ply_ready),
    .ply_period(ply_period), .ply_duration(ply_duration), .ply_volume(ply_volume),
    .ply_abort(ply_abort), .audio_out(audio_out), .busy(busy), .done(done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] vec(logic [VOL_W-1:0] a, logic b, logic d, logic r);
    return {a, b, d, r};
  endfunction

  // One entry per cycle after the handshake edge: note cycles, done (unless
  // aborted), then one idle cycle.
  task automatic push_note(int p, int d, int v, int abort_at);
    int n;
    bit aborted;
    logic [VOL_W-1:0] a;
    n = d * TICK_DIV;
    aborted = 1'b0;
    if (abort_at >= 0 && abort_at < n) begin
      n = abort_at + 1;
      aborted = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      a = (p != 0 && ((k / p) % 2 == 0)) ? VOL_W'(v) : '0;
      exp_q.push_back(vec(a, 1'b1, 1'b0, 1'b0));
    end
    if (!aborted) exp_q.push_back(vec('0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(vec('0, 1'b0, 1'b0, 1'b1));
  endtask

  // ---------------- drivers ----------------
  task automatic scramble();
    ply_period   = DATA_W'($urandom);
    ply_duration = DATA_W'($urandom);
    ply_volume   = VOL_W'($urandom);
  endtask

  task automatic send_cmd(int p, int d, int v);
    int w;
    w = 0;
    while (ply_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) begin
      chk_cnt++;
      $display("FAIL send_cmd_ready_timeout ready=%b required=1", ply_ready);
    end
    ply_period   = DATA_W'(p);
    ply_duration = DATA_W'(d);
    ply_volume   = VOL_W'(v);
    ply_valid    = 1'b1;
    @(posedge clk); #1;
    ply_valid = 1'b0;
    scramble();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    chk_cnt++;
    if (obs !== vec('0, 1'b0, 1'b0, 1'b0))
      $display("FAIL reset_hold obs=%h required=%h", obs, vec('0, 1'b0, 1'b0, 1'b0));
    else pass_cnt++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (obs !== vec('0, 1'b0, 1'b0, 1'b1))
      $display("FAIL reset_release obs=%h required=%h", obs, vec('0, 1'b0, 1'b0, 1'b1));
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [OW-1:0] e;
    send_cmd(2, 3, 8'h80);
    push_note(2, 3, 8'h80, -1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL basic cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      scramble();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rest();
    logic [OW-1:0] e;
    send_cmd(0, 2, 8'hFF);
    push_note(0, 2, 8'hFF, -1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL rest cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      scramble();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_dur();
    logic [OW-1:0] e;
    // abort held high: accepted with valid in IDLE, ignored in DONE
    ply_abort = 1'b1;
    send_cmd(3, 0, 8'h7E);
    push_note(3, 0, 8'h7E, -1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL zero_dur cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    ply_abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [OW-1:0] e;
    // mid-note abort at cycle 5 of a 12-cycle note, then quiet idle
    send_cmd(2, 3, 8'h80);
    push_note(2, 3, 8'h80, 5);
    repeat (3) exp_q.push_back(vec('0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL abort_mid cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      ply_abort = (k == 5);
      @(posedge clk); #1;
    end
    // abort coinciding with the final tick wins
    send_cmd(1, 1, 8'h21);
    push_note(1, 1, 8'h21, 3);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL abort_last cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      ply_abort = (k == 3);
      @(posedge clk); #1;
    end
    ply_abort = 1'b0;
    // abort alone in IDLE does nothing
    ply_abort = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (obs !== vec('0, 1'b0, 1'b0, 1'b1))
        $display("FAIL abort_idle cyc=%0d obs=%h required=%h", k, obs, vec('0, 1'b0, 1'b0, 1'b1));
      else pass_cnt++;
    end
    // abort together with valid in IDLE: command accepted, full note plays
    send_cmd(1, 1, 8'h5A);
    ply_abort = 1'b0;
    push_note(1, 1, 8'h5A, -1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL abort_with_valid cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] e;
    ply_period = 16'd1; ply_duration = 16'd2; ply_volume = 8'h33;
    ply_valid = 1'b1;
    @(posedge clk); #1;
    push_note(1, 2, 8'h33, -1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL b2b_first cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      if (exp_q.size() <= 1) begin
        ply_period = 16'd3; ply_duration = 16'd1; ply_volume = 8'hC4;
      end else begin
        scramble();
      end
      @(posedge clk); #1;
    end
    ply_valid = 1'b0;
    push_note(3, 1, 8'hC4, -1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL b2b_second cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      scramble();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] e;
    send_cmd(3, 4, 8'h55);
    push_note(3, 4, 8'h55, -1);
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs !== e) $display("FAIL reset_mid_play cyc=%0d obs=%h required=%h", k, obs, e);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (obs !== vec('0, 1'b0, 1'b0, 1'b0))
      $display("FAIL reset_mid_async obs=%h required=%h", obs, vec('0, 1'b0, 1'b0, 1'b0));
    else pass_cnt++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (obs !== vec('0, 1'b0, 1'b0, 1'b1))
        $display("FAIL reset_mid_after cyc=%0d obs=%h required=%h", k, obs, vec('0, 1'b0, 1'b0, 1'b1));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] e;
    int p, d, v, ab;
    for (int n = 0; n < 12; n++) begin
      p  = int'($urandom_range(0, 5));
      d  = int'($urandom_range(0, 3));
      v  = int'($urandom_range(1, 255));
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(0, d * TICK_DIV));
      send_cmd(p, d, v);
      push_note(p, d, v, ab);
      for (int k = 0; exp_q.size() > 0; k++) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (obs !== e)
          $display("FAIL random n=%0d p=%0d d=%0d ab=%0d cyc=%0d obs=%h required=%h",
                   n, p, d, ab, k, obs, e);
        else pass_cnt++;
        ply_abort = (k == ab);
        scramble();
        @(posedge clk); #1;
      end
      ply_abort = 1'b0;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_rest();
    test_zero_dur();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ply_unit.md
PLY_UNIT -- requirements
Module: ply_unit

Interface
REQ-001 Parameter DATA_W, default 16, operand width of period and duration.
REQ-002 Parameter TICK_DIV, default 1000, clock cycles per duration tick; legal range >=1.
REQ-003 Parameter VOL_W, default 8, width of volume field and audio output.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ply_valid  in  1  CPU issues a PLY command.
REQ-007 ply_ready  out  1  unit can accept a command.
REQ-008 ply_period  in  DATA_W  half-period of square tone in clk cycles, from the rs1 operand; 0 means rest (silence).
REQ-009 ply_duration  in  DATA_W  note length in ticks, from the rs2 operand.
REQ-010 ply_volume  in  VOL_W  amplitude, from the bitmap-register operand.
REQ-011 ply_abort  in  1  terminate the current note.
REQ-012 audio_out  out  VOL_W  sample: volume in high phase, 0 otherwise.
REQ-013 busy  out  1  command in progress; CPU stalls further PLY while high.
REQ-014 done  out  1  one-cycle pulse on normal note completion.

Function
REQ-015 FSM states shall be IDLE, PLAY and DONE.
REQ-016 ply_ready shall be 1 only in IDLE; a handshake occurs when ply_valid and ply_ready are both 1 at a rising edge.
REQ-017 On handshake, the unit shall register period, duration and volume, and move to PLAY if duration!=0, else to DONE.
REQ-018 Operand inputs shall be ignored outside the handshake cycle; changes during PLAY have no effect.
REQ-019 In PLAY, the phase counter shall count 0..period-1; at period-1 it shall wrap to 0 and toggle the phase bit.
REQ-020 Phase shall be high in the first cycle after the handshake; audio_out shall equal the registered volume when phase is high and period!=0, else 0.
REQ-021 The tick prescaler shall count 0..TICK_DIV-1 in PLAY; at wrap, the duration counter shall decrement by 1.
REQ-022 When the duration counter decrements from 1 to 0, the FSM shall enter DONE; PLAY shall last exactly duration*TICK_DIV cycles.
REQ-023 DONE shall last one cycle with done=1, audio_out=0, and ply_ready=0, then return to IDLE.
REQ-024 busy shall be 1 in PLAY and DONE, and 0 in IDLE.
REQ-025 ply_abort in PLAY shall force IDLE at the next edge with audio_out=0 and no done pulse.
REQ-026 ply_abort in IDLE or DONE shall be ignored; ply_valid and ply_abort together in IDLE shall accept the command.
REQ-027 If ply_abort and the final tick coincide in PLAY, abort shall win: IDLE next, no done.
REQ-028 Counters shall not overflow: duration is at most 2^DATA_W-1 ticks, and the phase counter is DATA_W bits wide.

Reset
REQ-029 While rst_n=0, the unit shall be in IDLE with all counters and phase at 0, audio_out=0, busy=0, done=0, and ply_ready=0.
REQ-030 ply_ready shall assert in the first cycle after rst_n deasserts; reset mid-note shall abandon the note with no done pulse.

Verification
REQ-031 TICK_DIV=4, accept period=2, duration=3, volume=0x80 -> audio_out 80,80,0,0 repeating for 12 cycles, then done for 1 cycle, then ready.
REQ-032 period=0, duration=2, TICK_DIV=4 -> audio_out=0 for 8 cycles, busy=1, then done pulse.
REQ-033 duration=0 -> DONE in the next cycle, done=1 for 1 cycle, no audio, IDLE after.
REQ-034 ply_abort at cycle 5 of a 12-cycle note -> IDLE next edge, audio_out=0, done never asserted.
REQ-035 ply_valid held high through a note with changing operands -> exactly one handshake per IDLE entry; the second command uses the operands present when ply_ready was 1.
REQ-036 rst_n pulsed low mid-PLAY -> outputs 0 immediately (asynchronously); ready=1 after release; no done.
